// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP word, prefetch entry payload.
package mips_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetchState_e;

  // One prefetch slot: the PC+4 of the word travels with it so decode gets both together.
  typedef struct packed {
    logic [INSTR_W-1:0] pcPlus4;
    logic [INSTR_W-1:0] instr;
  } fetchEntry_t;

  // Clear the two byte-offset bits of a target address.
  function automatic logic [INSTR_W-1:0] wordAlign(input logic [INSTR_W-1:0] addr);
    return addr & {{(INSTR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular buffer of fetchEntry_t with push/pop/flush.
// The head is held in a register so the IF/ID-facing outputs are flop-driven; a push
// becomes visible at the head on the edge after it is written (no bypass).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, pushData      write one entry (never into a full buffer unless popping too)
//   pop                 retire the head; ignored when empty
//   flush               empty the buffer; overrides push and pop
//   head, headValid     registered head entry (all-zero when empty) and its valid flag
//   full                all DEPTH slots occupied
module ifetch_fifo
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetchEntry_t pushData,
  output fetchEntry_t head,
  output logic        headValid,
  output logic        full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetchEntry_t      mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nextCount;
  logic             doPush;
  logic             doPop;
  fetchEntry_t      nextHead;
  logic             nextHeadValid;

  assign full = (count == CNT_W'(DEPTH));

  // Next occupancy and next head; the head register mirrors mem[rdPtr] except that
  // a word pushed into an empty (or just-emptied) buffer is taken straight from pushData.
  always_comb begin
    doPush        = push & ~flush;
    doPop         = pop & ~flush & (count != '0);
    nextCount     = count;
    nextHead      = head;
    nextHeadValid = headValid;
    if (doPush && !doPop) begin
      nextCount = count + CNT_W'(1);
    end else if (!doPush && doPop) begin
      nextCount = count - CNT_W'(1);
    end
    if (flush || (nextCount == '0)) begin
      nextHead      = '0;
      nextHeadValid = 1'b0;
    end else if ((count == '0) || (doPop && (count == CNT_W'(1)))) begin
      nextHead      = pushData;
      nextHeadValid = 1'b1;
    end else if (doPop) begin
      nextHead      = mem[rdPtr + PTR_W'(1)];
      nextHeadValid = 1'b1;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      head      <= '0;
      headValid <= 1'b0;
    end else begin
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + PTR_W'(1);
        if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      end
      count     <= flush ? '0 : nextCount;
      head      <= nextHead;
      headValid <= nextHeadValid;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // The issue gate reserves a slot before requesting, so this can only fire on a logic bug.
  pushIntoFull: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Fetch stage: owns the PC, issues one word fetch at a time over a req/ack handshake with
// variable latency, buffers returned words and presents {instr, pc+4} to IF/ID.
// Optional build macro IFETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   stall_f                       decode will not accept this cycle
//   redirect, redirect_pc         branch/jump redirect from decode (low two bits ignored)
//   imem_req, imem_addr           fetch request; address held until ack
//   imem_ack, imem_rdata          one-cycle response pulse and data
//   instr_valid_f, instr_f,       head of the prefetch buffer; NOP and 0 when empty
//   pc_plus4_f
//   perf_fetch_cnt                (IFETCH_PERF_CNT_EN) acks accepted, including dropped ones
//   perf_bubble_cnt               (IFETCH_PERF_CNT_EN) cycles decode was ready but got a bubble
module ifetch_prefetch_unit
  import mips_pipe_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid_f,
  output logic [INSTR_W-1:0] instr_f,
  output logic [INSTR_W-1:0] pc_plus4_f
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  fetchState_e        state;
  fetchState_e        nextState;
  logic [INSTR_W-1:0] fetchPc;
  logic               issue;
  logic               pushEn;
  logic               popEn;
  logic               fifoFull;
  fetchEntry_t        pushEntry;
  fetchEntry_t        fifoHead;

  // imem_addr is the PC of the outstanding request while in WAIT.
  assign pushEntry = '{pcPlus4: imem_addr + 32'd4, instr: imem_rdata};
  assign popEn     = instr_valid_f & ~stall_f;
  assign instr_f   = fifoHead.instr;
  assign pc_plus4_f = fifoHead.pcPlus4;

  // Fetch sequencing: an ack is only ever accepted from WAIT/DROP, and a request is only
  // issued from IDLE, so a new request can never coincide with an ack.
  always_comb begin
    nextState = state;
    issue     = 1'b0;
    pushEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect && !fifoFull) begin
          nextState = WAIT;
          issue     = 1'b1;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          nextState = IDLE;
          pushEn    = ~redirect;
        end else if (redirect) begin
          nextState = DROP;
        end
      end
      DROP: begin
        if (imem_ack) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State, request handshake and PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetchPc   <= RESET_PC;
    end else begin
      state    <= nextState;
      imem_req <= (nextState != IDLE);
      if (issue) imem_addr <= fetchPc;
      if (redirect) begin
        fetchPc <= wordAlign(redirect_pc);
      end else if (pushEn) begin
        fetchPc <= fetchPc + 32'd4;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (pushEn),
    .pop      (popEn),
    .flush    (redirect),
    .pushData (pushEntry),
    .head     (fifoHead),
    .headValid(instr_valid_f),
    .full     (fifoFull)
  );

`ifdef IFETCH_PERF_CNT_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (imem_ack && (state != IDLE)) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!stall_f && !instr_valid_f)  perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: a variable-latency instruction memory, a program-order
// stream model (expected {pc+4, instr} queue restarted on reset/redirect) and a negedge monitor.
module tb_ifetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid_f;
  logic [31:0] instr_f;
  logic [31:0] pc_plus4_f;

  always #5 clk = ~clk;

  ifetch_prefetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_f      (stall_f),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid_f(instr_valid_f),
    .instr_f      (instr_f),
    .pc_plus4_f   (pc_plus4_f)
  );

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } expItem_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  expItem_t    expQ[$];
  expItem_t    expItem;
  logic [31:0] genPc;
  logic [31:0] salt;
  bit          memOn;
  bit          memPending;
  int          memCnt;
  int          maxLat;
  int          ackCnt;
  logic [31:0] memAddr;
  logic [31:0] savedAddr;
  logic        prevReq;
  logic        prevAck;
  logic [31:0] prevAddr;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program order from a start PC: consecutive words, 32-bit wrap.
  function automatic void topUp();
    while (expQ.size() < 16) begin
      expQ.push_back('{pc4: genPc + 32'd4, instr: memWord(genPc)});
      genPc = genPc + 32'd4;
    end
  endfunction

  function automatic void restartStream(input logic [31:0] pc);
    expQ.delete();
    genPc = pc & 32'hFFFF_FFFC;
    topUp();
  endfunction

  // Advance one cycle, then play the memory for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (reset) begin
      memPending = 1'b0;
    end else if (memOn) begin
      if (memPending) begin
        if (memCnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memWord(memAddr);
          memPending = 1'b0;
          ackCnt++;
        end else begin
          memCnt--;
        end
      end else if (imem_req) begin
        memPending = 1'b1;
        memAddr    = imem_addr;
        memCnt     = int'($urandom_range(maxLat, 1)) - 1;
      end
    end
    topUp();
  endtask

  task automatic doRedirect(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    restartStream(tgt);
    tick();
    redirect    = 1'b0;
    redirect_pc = $urandom;
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b1;
    restartStream(RESET_PC);
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!imem_req && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(imem_req), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((imem_req || memPending) && n < 50) begin
      tick();
      n++;
    end
    check(name, 32'(imem_req || memPending), 32'd0);
  endtask

  // Monitor: consumes the head whenever decode takes it and checks it against the stream.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_imem_req", 32'(imem_req), 32'd0);
      check("reset_valid", 32'(instr_valid_f), 32'd0);
      check("reset_instr", instr_f, 32'd0);
      check("reset_pc4", pc_plus4_f, 32'd0);
    end else begin
      if (prevReq && !prevAck && imem_req) check("addr_hold", imem_addr, prevAddr);
      if (!instr_valid_f) begin
        check("bubble_instr", instr_f, 32'd0);
        check("bubble_pc4", pc_plus4_f, 32'd0);
      end else if (!stall_f && !redirect) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stream_underflow: got pc4 %h, expected nothing", pc_plus4_f);
        end else begin
          expItem = expQ.pop_front();
          check("pc_plus4_f", pc_plus4_f, expItem.pc4);
          check("instr_f", instr_f, expItem.instr);
          pops++;
        end
      end
    end
    prevReq  = imem_req && !reset;
    prevAck  = imem_ack;
    prevAddr = imem_addr;
  end

  initial begin
    salt        = $urandom;
    reset       = 1'b1;
    stall_f     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    memOn       = 1'b1;
    memPending  = 1'b0;
    memCnt      = 0;
    maxLat      = 1;
    ackCnt      = 0;
    restartStream(RESET_PC);
    repeat (3) tick();
    reset = 1'b0;

    // Sequential fetch from RESET_PC; first word two cycles after the request.
    waitReq("t1_first_req");
    check("t1_first_addr", imem_addr, RESET_PC);
    tick();
    check("t1_valid_after_1", 32'(instr_valid_f), 32'd0);
    tick();
    check("t1_valid_after_2", 32'(instr_valid_f), 32'd1);
    check("t1_first_pc4", pc_plus4_f, RESET_PC + 32'd4);
    repeat (30) tick();

    // Long stall from an empty buffer: exactly DEPTH words, then requests stop.
    waitIdle("t2_idle");
    stall_f = 1'b1;
    ackCnt  = 0;
    doRedirect(32'h0000_0100);
    repeat (20) tick();
    check("t2_words_buffered", 32'(ackCnt), 32'(DEPTH));
    check("t2_req_low", 32'(imem_req), 32'd0);
    repeat (3) tick();
    check("t2_head_instr", instr_f, memWord(32'h0000_0100));
    check("t2_head_pc4", pc_plus4_f, 32'h0000_0104);
    stall_f = 1'b0;
    repeat (20) tick();

    // Redirect while waiting: late ack is dropped and refetch starts at the aligned target.
    waitIdle("t3_idle");
    memOn = 1'b0;
    waitReq("t3_req");
    savedAddr = imem_addr;
    doRedirect(32'h0000_0043);
    tick();
    tick();
    check("t3_req_held", 32'(imem_req), 32'd1);
    check("t3_addr_held", imem_addr, savedAddr);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0001;
    tick();
    check("t3_req_dropped", 32'(imem_req), 32'd0);
    check("t3_fifo_empty", 32'(instr_valid_f), 32'd0);
    tick();
    check("t3_new_req", 32'(imem_req), 32'd1);
    check("t3_new_addr", imem_addr, 32'h0000_0040);
    memOn = 1'b1;
    repeat (20) tick();

    // Redirect and ack in the same cycle with the buffer about to fill.
    waitIdle("t4_idle");
    memOn   = 1'b0;
    stall_f = 1'b1;
    doRedirect(32'h0000_2000);
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      waitReq("t4_fill_req");
      imem_ack   = 1'b1;
      imem_rdata = memWord(imem_addr);
      tick();
    end
    waitReq("t4_last_req");
    check("t4_head_valid", 32'(instr_valid_f), 32'd1);
    stall_f     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3000;
    restartStream(32'h0000_3000);
    imem_ack    = 1'b1;
    imem_rdata  = memWord(imem_addr);
    tick();
    redirect = 1'b0;
    check("t4_flushed", 32'(instr_valid_f), 32'd0);
    check("t4_req_low", 32'(imem_req), 32'd0);
    memOn = 1'b1;
    repeat (20) tick();

    // PC wrap at the top of the address space.
    doRedirect(32'hFFFF_FFF8);
    repeat (20) tick();

    // Reset mid-request, then a stray ack in the first cycle after reset.
    waitIdle("t6_idle");
    memOn = 1'b0;
    waitReq("t6_req");
    tick();
    reset = 1'b1;
    restartStream(RESET_PC);
    #1;
    check("t6_req_drop_async", 32'(imem_req), 32'd0);
    tick();
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t6_restart_req", 32'(imem_req), 32'd1);
    check("t6_restart_addr", imem_addr, RESET_PC);
    check("t6_stray_ignored", 32'(instr_valid_f), 32'd0);
    memOn = 1'b1;
    repeat (20) tick();

    // Randomised traffic: variable latency, stalls, redirects (some near the wrap), one reset.
    maxLat = 4;
    for (int i = 0; i < 3000; i++) begin
      stall_f = ($urandom_range(99) < 30);
      if (i == 1500) begin
        doReset(2);
      end else if ($urandom_range(99) < 3) begin
        if ($urandom_range(1) == 0) doRedirect($urandom);
        else doRedirect(32'hFFFF_FF00 | 32'($urandom_range(255)));
      end else begin
        tick();
      end
    end
    stall_f = 1'b0;
    repeat (10) tick();
    check("enough_traffic", 32'(pops > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
